result_streamer: RTL and testbench



---
 rtl/result_streamer_pkg.sv | 37 +++
 rtl/result_streamer_gap_counter.sv | 36 +++
 rtl/result_streamer.sv | 144 ++++++++++++++
 tb/tb_result_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_streamer_pkg.sv
// Shared encodings for result_streamer: output-mux selects, FSM states, frame length.
// Frame length grows to 5 bytes when RESULT_STREAMER_CHECKSUM_EN is defined.
package result_streamer_pkg;

    localparam logic [1:0] MUX_SEL_COUNTER_CARRY  = 2'd0;
    localparam logic [1:0] MUX_SEL_COUNTER_VALUE  = 2'd1;
    localparam logic [1:0] MUX_SEL_REGISTER_2_MSB = 2'd2;
    localparam logic [1:0] MUX_SEL_REGISTER_2_LSB = 2'd3;

    localparam logic [2:0] MUX_SOURCES = 3'd4;

`ifdef RESULT_STREAMER_CHECKSUM_EN
    localparam int unsigned FRAME_LEN      = 5;
    localparam logic [2:0]  CHECKSUM_INDEX = 3'd4;
`else
    localparam int unsigned FRAME_LEN      = 4;
`endif
    localparam logic [2:0] LAST_INDEX = 3'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CAPTURE,
        ST_SEND,
        ST_GAP
    } state_t;

    function automatic logic [1:0] sel_for_index(input logic [2:0] index);
        case (index)
            3'd0:    return MUX_SEL_COUNTER_CARRY;
            3'd1:    return MUX_SEL_COUNTER_VALUE;
            3'd2:    return MUX_SEL_REGISTER_2_MSB;
            default: return MUX_SEL_REGISTER_2_LSB;
        endcase
    endfunction

endpackage

// File: rtl/result_streamer_gap_counter.sv
// Loadable down-counter timing the idle gap between bytes of a frame.
// expire_o flags the final counted cycle so the FSM leaves GAP on that edge.
module result_streamer_gap_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       expire_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q <= 4'd1);

endmodule

// File: rtl/result_streamer.sv
// Walks the output mux through its four sources and streams one byte per source
// on a valid/ready link. RESULT_STREAMER_CHECKSUM_EN appends an XOR checksum byte.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int unsigned IDLE_GAP   = 0,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mux_data,
    output logic [1:0]            mux_sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [2:0]            index_q, index_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  gap_load;
    logic                  gap_en;
    logic                  gap_expire;
    logic [DATA_WIDTH-1:0] capture_byte;

    result_streamer_gap_counter u_gap_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (4'(IDLE_GAP)),
        .en_i       (gap_en),
        .expire_o   (gap_expire)
    );

`ifdef RESULT_STREAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            xor_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            xor_q <= xor_q ^ mux_data;
        end
    end

    assign capture_byte = (index_q == CHECKSUM_INDEX) ? xor_q : mux_data;
`else
    assign capture_byte = mux_data;
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        mux_sel_d   = mux_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        gap_load    = 1'b0;
        gap_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                    index_d = 3'd0;
                end
            end
            ST_SELECT: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_data_d  = capture_byte;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (index_q == LAST_INDEX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = 3'(index_q + 3'd1);
                        if (IDLE_GAP > 0) begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end else begin
                            state_d = ST_SELECT;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_en = 1'b1;
                if (gap_expire) begin
                    state_d = ST_SELECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Select is set on entry to SELECT so the mux settles for a full cycle before CAPTURE.
        if (state_d == ST_SELECT && index_d < MUX_SOURCES) begin
            mux_sel_d = sel_for_index(index_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= 3'd0;
            mux_sel_q   <= MUX_SEL_COUNTER_CARRY;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            mux_sel_q   <= mux_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign mux_sel   = mux_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: frame content, latency, stalls, gaps,
// restart handling and mid-frame reset against a modelled output mux.
module tb_result_streamer;
    import result_streamer_pkg::*;

`ifdef RESULT_STREAMER_CHECKSUM_EN
    localparam int EXP_LEN = 5;
`else
    localparam int EXP_LEN = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic use_gap = 1'b0;

    logic [1:0] sel_a, sel_b;
    logic [7:0] mux_a, mux_b, data_a, data_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic       start_a, start_b;

    logic [1:0] m_sel;
    logic [7:0] m_data;
    logic       m_valid, m_busy, m_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_bytes [0:4] = '{8'h01, 8'h5A, 8'hBE, 8'hEF, 8'h0A};
    logic [1:0] exp_sel   [0:3] = '{MUX_SEL_COUNTER_CARRY, MUX_SEL_COUNTER_VALUE,
                                    MUX_SEL_REGISTER_2_MSB, MUX_SEL_REGISTER_2_LSB};

    logic [7:0] got_bytes [0:7];
    logic [1:0] got_sel   [0:7];
    int         valid_cnt [0:7];
    int         got_n, first_valid, done_at, min_gap;
    bit         hold_bad;

    always #5 clk = ~clk;

    // Upstream state: carry=1, value=0x5A, reg2=0xBEEF.
    function automatic logic [7:0] mux_model(input logic [1:0] sel);
        case (sel)
            MUX_SEL_COUNTER_CARRY:  return 8'h01;
            MUX_SEL_COUNTER_VALUE:  return 8'h5A;
            MUX_SEL_REGISTER_2_MSB: return 8'hBE;
            default:                return 8'hEF;
        endcase
    endfunction

    assign mux_a   = mux_model(sel_a);
    assign mux_b   = mux_model(sel_b);
    assign start_a = start & ~use_gap;
    assign start_b = start & use_gap;

    assign m_sel   = use_gap ? sel_b   : sel_a;
    assign m_data  = use_gap ? data_b  : data_a;
    assign m_valid = use_gap ? valid_b : valid_a;
    assign m_busy  = use_gap ? busy_b  : busy_a;
    assign m_done  = use_gap ? done_b  : done_a;

    result_streamer #(.IDLE_GAP(0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .mux_data  (mux_a),
        .mux_sel   (sel_a),
        .out_data  (data_a),
        .out_valid (valid_a),
        .out_ready (out_ready),
        .busy      (busy_a),
        .done      (done_a)
    );

    result_streamer #(.IDLE_GAP(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .mux_data  (mux_b),
        .mux_sel   (sel_b),
        .out_data  (data_b),
        .out_valid (valid_b),
        .out_ready (out_ready),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then follows the frame; cyc is the index of the edge just
    // taken, counting the edge that samples start as 0.
    task automatic run_frame(input int stall_idx, input int stall_len, input bit restart_mid);
        int         stalled = 0;
        int         gap_run = 0;
        logic [7:0] held = 8'h00;
        got_n = 0; first_valid = -1; done_at = -1; min_gap = 1000; hold_bad = 1'b0;
        for (int i = 0; i < 8; i++) valid_cnt[i] = 0;
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            start = (restart_mid && cyc == 4);
            if (m_done) begin
                done_at = cyc;
                break;
            end
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (valid_cnt[got_n] == 0) begin
                    held = m_data;
                    got_sel[got_n] = m_sel;
                    if (got_n > 0 && gap_run < min_gap) min_gap = gap_run;
                end else if (m_data !== held) begin
                    hold_bad = 1'b1;
                end
                valid_cnt[got_n]++;
                gap_run = 0;
                if (got_n == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    got_bytes[got_n] = m_data;
                    if (got_n < 7) got_n++;
                end
            end else begin
                gap_run++;
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (sel_a !== MUX_SEL_COUNTER_CARRY) begin errors++; $display("FAIL reset_mux_sel got=%0d want=%0d", sel_a, MUX_SEL_COUNTER_CARRY); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_a); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        run_frame(-1, 0, 1'b0);
        checks++; if (got_n !== EXP_LEN) begin errors++; $display("FAIL basic_len got=%0d want=%0d", got_n, EXP_LEN); end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL basic_first_valid got=%0d want=2", first_valid); end
        checks++; if (done_at !== 3 * EXP_LEN) begin errors++; $display("FAIL basic_done_at got=%0d want=%0d", done_at, 3 * EXP_LEN); end
        for (int i = 0; i < EXP_LEN; i++) begin
            checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_bytes[i], exp_bytes[i]); end
            checks++; if (valid_cnt[i] !== 1) begin errors++; $display("FAIL basic_valid_cycles%0d got=%0d want=1", i, valid_cnt[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_sel[i] !== exp_sel[i]) begin errors++; $display("FAIL basic_sel%0d got=%0d want=%0d", i, got_sel[i], exp_sel[i]); end
        end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got=%b want=0", m_busy); end
        tick();
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b want=0", m_done); end
    endtask

    task automatic test_stall();
        tick();
        run_frame(2, 5, 1'b0);
        checks++; if (got_n !== EXP_LEN) begin errors++; $display("FAIL stall_len got=%0d want=%0d", got_n, EXP_LEN); end
        checks++; if (valid_cnt[2] !== 6) begin errors++; $display("FAIL stall_valid_cycles got=%0d want=6", valid_cnt[2]); end
        checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL stall_data_held got=%b want=0", hold_bad); end
        checks++; if (done_at !== 3 * EXP_LEN + 5) begin errors++; $display("FAIL stall_done_at got=%0d want=%0d", done_at, 3 * EXP_LEN + 5); end
        for (int i = 0; i < EXP_LEN; i++) begin
            checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL stall_byte%0d got=%h want=%h", i, got_bytes[i], exp_bytes[i]); end
        end
    endtask

    task automatic test_gap();
        tick();
        use_gap = 1'b1;
        tick();
        run_frame(-1, 0, 1'b0);
        checks++; if (got_n !== EXP_LEN) begin errors++; $display("FAIL gap_len got=%0d want=%0d", got_n, EXP_LEN); end
        checks++; if (min_gap < 3) begin errors++; $display("FAIL gap_min_low got=%0d want>=3", min_gap); end
        checks++; if (done_at !== 6 * EXP_LEN - 3) begin errors++; $display("FAIL gap_done_at got=%0d want=%0d", done_at, 6 * EXP_LEN - 3); end
        for (int i = 0; i < EXP_LEN; i++) begin
            checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL gap_byte%0d got=%h want=%h", i, got_bytes[i], exp_bytes[i]); end
        end
        tick();
        use_gap = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        run_frame(-1, 0, 1'b1);
        checks++; if (got_n !== EXP_LEN) begin errors++; $display("FAIL b2b_mid_len got=%0d want=%0d", got_n, EXP_LEN); end
        checks++; if (done_at !== 3 * EXP_LEN) begin errors++; $display("FAIL b2b_mid_done_at got=%0d want=%0d", done_at, 3 * EXP_LEN); end
        // Start issued in the done cycle must launch a fresh frame at once.
        run_frame(-1, 0, 1'b0);
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL b2b_restart_first_valid got=%0d want=2", first_valid); end
        checks++; if (done_at !== 3 * EXP_LEN) begin errors++; $display("FAIL b2b_restart_done_at got=%0d want=%0d", done_at, 3 * EXP_LEN); end
        checks++; if (got_bytes[0] !== exp_bytes[0] || got_bytes[3] !== exp_bytes[3]) begin
            errors++; $display("FAIL b2b_restart_bytes got=%h/%h want=%h/%h", got_bytes[0], got_bytes[3], exp_bytes[0], exp_bytes[3]);
        end
        tick();
        tick();
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue busy got=%b want=0", m_busy); end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen = 0;
        int busy_seen = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (valid_a !== 1'b1 || data_a !== 8'h5A) begin errors++; $display("FAIL rstmid_in_send1 valid=%b data=%h want=1/5a", valid_a, data_a); end
        reset = 1'b1;
        tick();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b want=0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy_a); end
        checks++; if (sel_a !== MUX_SEL_COUNTER_CARRY) begin errors++; $display("FAIL rstmid_mux_sel got=%0d want=%0d", sel_a, MUX_SEL_COUNTER_CARRY); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rstmid_out_data got=%h want=00", data_a); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_a) done_seen++;
            if (busy_a) busy_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", done_seen); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL rstmid_no_continue got=%0d want=0", busy_seen); end
        run_frame(-1, 0, 1'b0);
        checks++; if (got_n !== EXP_LEN) begin errors++; $display("FAIL rstmid_after_len got=%0d want=%0d", got_n, EXP_LEN); end
        checks++; if (done_at !== 3 * EXP_LEN) begin errors++; $display("FAIL rstmid_after_done_at got=%0d want=%0d", done_at, 3 * EXP_LEN); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_gap();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
